clk_period_monitor: RTL and testbench

Synthesizable frequency and duty checker that sits directly downstream of the clock buffer. It samples the buffered clock as a data signal in the system `clk` domain and measures one full period and one high phase in `clk` cycles. It compares the period against an expected value and reports the result with a single-cycle `done` pulse. This is the in-silicon counterpart of the bench-level frequency check on the buffer output.

---
 rtl/clk_period_monitor.sv | 166 ++++++++++++++++
 tb/tb_clk_period_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// Measures one period and one high phase of an asynchronous clock-like input in clk cycles.
// Results are compared against an expected period and reported with a one-cycle done pulse.
module clk_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             freq_err,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a one-cycle request, accepted only in IDLE (busy low, done low);
    // results are valid in the cycle done is high and held until the next accepted start.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W:0]   PER_HI    = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W:0]   PER_LO    = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             fall_seen;
    logic             wait_last;
    logic             per_bad;

    // Synchronizer plus history flop; the fixed latency cancels out of every interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign per_bad   = ({1'b0, cnt} > PER_HI) || ({1'b0, cnt} < PER_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (wait_last) begin
                    state_nxt = DONE;
                end
            end
            MEASURE: begin
                if (rise || wait_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state == ARM) || (state == MEASURE);
        done      = (state == DONE);
        dbg_state = state;
    end

    // A rise always wins over a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wait_cnt  <= '0;
            fall_seen <= 1'b0;
            period    <= '0;
            high_time <= '0;
            freq_err  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        wait_cnt  <= '0;
                        fall_seen <= 1'b0;
                        period    <= '0;
                        high_time <= '0;
                        freq_err  <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cnt      <= CNT_W'(1);
                        wait_cnt <= '0;
                    end else if (wait_last) begin
                        timeout  <= 1'b1;
                        freq_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (fall && !fall_seen) begin
                        high_time <= cnt;
                        fall_seen <= 1'b1;
                    end
                    if (rise) begin
                        period   <= cnt;
                        freq_err <= per_bad;
                    end else if (wait_last) begin
                        timeout  <= 1'b1;
                        freq_err <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed and randomized checks of clk_period_monitor against a waveform-level reference:
// a mon_clk of H high / L low clk cycles must measure period H+L and high time H.
module tb_clk_period_monitor;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 10;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 1024;
    localparam int BUDGET     = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mon_clk = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             freq_err;
    logic             timeout;
    logic [1:0]       dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // 0: periodic hi_len/lo_len, 1: stuck low, 2: stuck high
    int gen_mode = 1;
    int hi_len = 5;
    int lo_len = 5;
    int gen_cyc = 0;

    clk_period_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .mon_clk(mon_clk), .start(start),
        .busy(busy), .done(done), .period(period), .high_time(high_time),
        .freq_err(freq_err), .timeout(timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // mon_clk changes 2 time units after each clk rise, away from the sampling edge.
    always begin
        @(posedge clk);
        #2;
        if (gen_mode == 0) begin
            gen_cyc = gen_cyc + 1;
            if (gen_cyc >= hi_len + lo_len) gen_cyc = 0;
            mon_clk = (gen_cyc < hi_len);
        end else begin
            gen_cyc = 0;
            mon_clk = (gen_mode == 2);
        end
    end

    function automatic int model_fe(input int p);
        return ((p > EXP_PERIOD + TOL) || (p < EXP_PERIOD - TOL)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_wave(input int h, input int l);
        hi_len   = h;
        lo_len   = l;
        gen_mode = 0;
        repeat (2 * (h + l) + 6) @(negedge clk);
    endtask

    // Issues start, waits for done and checks results; exp_len < 0 skips the latency check.
    task automatic run_meas(input string tag, input int exp_p, input int exp_h,
                            input int exp_fe, input int exp_to, input int exp_len,
                            input bit second_start, input bit lose_edge);
        int  cyc;
        int  dones;
        bit  seen;
        bit  issued;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, int'(busy), 1);
        cyc    = 0;
        dones  = 0;
        seen   = 1'b0;
        issued = 1'b0;
        if (lose_edge) gen_mode = 2;
        while (!seen && cyc < BUDGET) begin
            start = 1'b0;
            if (second_start && !issued && dbg_state == 2'd2) begin
                start  = 1'b1;
                issued = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                dones++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, int'(seen), 1);
        if (exp_len >= 0) check({tag, "_latency"}, cyc, exp_len);
        check({tag, "_period"}, int'(period), exp_p);
        check({tag, "_high_time"}, int'(high_time), exp_h);
        check({tag, "_freq_err"}, int'(freq_err), exp_fe);
        check({tag, "_timeout"}, int'(timeout), exp_to);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_drop"}, int'(done), 0);
        check({tag, "_held_period"}, int'(period), exp_p);
        repeat (10) begin
            if (done) dones++;
            @(negedge clk);
        end
        check({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        int h;
        int l;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_period", int'(period), 0);
        check("reset_high", int'(high_time), 0);
        check("reset_fe", int'(freq_err), 0);
        check("reset_to", int'(timeout), 0);

        set_wave(5, 5);
        run_meas("nominal", 10, 5, model_fe(10), 0, -1, 1'b0, 1'b0);

        set_wave(3, 8);
        run_meas("tol_edge", 11, 3, model_fe(11), 0, -1, 1'b0, 1'b0);
        set_wave(4, 10);
        run_meas("out_of_tol", 14, 4, model_fe(14), 0, -1, 1'b0, 1'b0);

        gen_mode = 1;
        repeat (10) @(negedge clk);
        run_meas("stuck_low", 0, 0, 1, 1, TIMEOUT, 1'b0, 1'b0);

        gen_mode = 1;
        repeat (10) @(negedge clk);
        run_meas("lost_edge", 0, 0, 1, 1, -1, 1'b0, 1'b1);

        set_wave(5, 5);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (dbg_state != 2'd2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_reached_measure", int'(dbg_state), 2);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_period", int'(period), 0);
        check("rst_mid_high", int'(high_time), 0);
        check("rst_mid_fe", int'(freq_err), 0);
        check("rst_mid_to", int'(timeout), 0);
        run_meas("after_rst", 10, 5, 0, 0, -1, 1'b0, 1'b0);

        run_meas("start_busy", 10, 5, 0, 0, -1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(2, 8);
            l = $urandom_range(2, 10);
            set_wave(h, l);
            run_meas($sformatf("rand%0d_h%0d_l%0d", i, h, l), h + l, h, model_fe(h + l), 0, -1,
                     1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
